proc_trace_capture: RTL and testbench

PROC_TRACE_CAPTURE -- requirements
Module: proc_trace_capture

---
 rtl/proc_trace_capture.sv | 162 ++++++++++++++++
 tb/tb_proc_trace_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_trace_capture.sv
// Processor trace capture: records regfile/dmem write events during a bounded
// run into a first-word-fall-through FIFO for a downstream reader.
module proc_trace_capture #(
   parameter int DEPTH       = 16,
   parameter int CYCLE_LIMIT = 100
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] address_imem,
   input  logic        ctrl_writeEnable,
   input  logic [4:0]  ctrl_writeReg,
   input  logic [31:0] data_writeReg,
   input  logic        wren,
   input  logic [11:0] address_dmem,
   input  logic [31:0] data,
   input  logic        trace_ready,
   output logic        trace_valid,
   output logic [1:0]  trace_kind,
   output logic [11:0] trace_pc,
   output logic [4:0]  trace_reg,
   output logic [31:0] trace_rdata,
   output logic [11:0] trace_maddr,
   output logic [31:0] trace_mdata,
   output logic [15:0] trace_cycle,
   output logic        halt,
   output logic        overflow,
   output logic [7:0]  dropped
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [15:0] LAST_CYC  = 16'(CYCLE_LIMIT - 1);
   localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALTED
   } state_t;

   typedef struct packed {
      logic [1:0]  kind;
      logic [11:0] pc;
      logic [4:0]  wreg;
      logic [31:0] rdata;
      logic [11:0] maddr;
      logic [31:0] mdata;
      logic [15:0] cyc;
   } entry_t;

   state_t      state_q, state_d;
   logic [15:0] cycle_q, cycle_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        overflow_q, overflow_d;
   logic [7:0]  dropped_q, dropped_d;
   entry_t      mem_q [DEPTH];

   logic   ev_reg;
   logic   ev;
   logic   empty;
   logic   full;
   logic   pop;
   logic   push;
   logic   drop;
   entry_t new_entry;
   entry_t head;

   // Pointers carry one extra bit so full and empty differ only in the MSB.
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign ev_reg = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
   assign ev     = (state_q == S_RUN) && (ev_reg || wren);
   assign pop    = !empty && trace_ready;
   assign push   = ev && (!full || pop);
   assign drop   = ev && full && !pop;

   always_comb begin
      new_entry      = '0;
      new_entry.kind = {wren, ev_reg};
      new_entry.pc   = address_imem;
      new_entry.cyc  = cycle_q;
      if (ev_reg) begin
         new_entry.wreg  = ctrl_writeReg;
         new_entry.rdata = data_writeReg;
      end
      if (wren) begin
         new_entry.maddr = address_dmem;
         new_entry.mdata = data;
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d    = state_q;
      cycle_d    = cycle_q;
      overflow_d = overflow_q;
      dropped_d  = dropped_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d    = S_RUN;
               cycle_d    = '0;
               overflow_d = 1'b0;
               dropped_d  = '0;
            end
         end
         S_RUN: begin
            cycle_d = cycle_q + 16'd1;
            if (cycle_q == LAST_CYC) state_d = S_HALTED;
            if (drop) begin
               overflow_d = 1'b1;
               if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cycle_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         dropped_q  <= '0;
      end else begin
         state_q    <= state_d;
         cycle_q    <= cycle_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         dropped_q  <= dropped_d;
      end
   end

   // NOTE: storage is deliberately not reset; emptying the pointers makes stale contents unreachable.
   always_ff @(posedge clock) begin
      if (reset && push) mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
   end

   assign head        = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign trace_valid = !empty;
   assign trace_kind  = head.kind;
   assign trace_pc    = head.pc;
   assign trace_reg   = head.wreg;
   assign trace_rdata = head.rdata;
   assign trace_maddr = head.maddr;
   assign trace_mdata = head.mdata;
   assign trace_cycle = head.cyc;
   assign halt        = (state_q == S_HALTED);
   assign overflow    = overflow_q;
   assign dropped     = dropped_q;

endmodule

// File: tb/tb_proc_trace_capture.sv
// Directed self-checking bench for proc_trace_capture (DEPTH=16, CYCLE_LIMIT=100).
module tb_proc_trace_capture;

   logic        clock;
   logic        reset;
   logic        start;
   logic [11:0] address_imem;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        wren;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        trace_ready;
   logic        trace_valid;
   logic [1:0]  trace_kind;
   logic [11:0] trace_pc;
   logic [4:0]  trace_reg;
   logic [31:0] trace_rdata;
   logic [11:0] trace_maddr;
   logic [31:0] trace_mdata;
   logic [15:0] trace_cycle;
   logic        halt;
   logic        overflow;
   logic [7:0]  dropped;

   int n_checks = 0;
   int n_fail   = 0;

   proc_trace_capture #(.DEPTH(16), .CYCLE_LIMIT(100)) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .address_imem    (address_imem),
      .ctrl_writeEnable(ctrl_writeEnable),
      .ctrl_writeReg   (ctrl_writeReg),
      .data_writeReg   (data_writeReg),
      .wren            (wren),
      .address_dmem    (address_dmem),
      .data            (data),
      .trace_ready     (trace_ready),
      .trace_valid     (trace_valid),
      .trace_kind      (trace_kind),
      .trace_pc        (trace_pc),
      .trace_reg       (trace_reg),
      .trace_rdata     (trace_rdata),
      .trace_maddr     (trace_maddr),
      .trace_mdata     (trace_mdata),
      .trace_cycle     (trace_cycle),
      .halt            (halt),
      .overflow        (overflow),
      .dropped         (dropped)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      start            = 1'b0;
      address_imem     = '0;
      ctrl_writeEnable = 1'b0;
      ctrl_writeReg    = '0;
      data_writeReg    = '0;
      wren             = 1'b0;
      address_dmem     = '0;
      data             = '0;
   endtask

   task automatic reg_write(input logic [4:0] r, input logic [31:0] v);
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = r;
      data_writeReg    = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      trace_ready = 1'b0;
      reset       = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_valid",    32'(trace_valid), 32'd0);
      check("rst_halt",     32'(halt),        32'd0);
      check("rst_overflow", 32'(overflow),    32'd0);
      check("rst_dropped",  32'(dropped),     32'd0);
      check("rst_kind",     32'(trace_kind),  32'd0);
      check("rst_cycle",    32'(trace_cycle), 32'd0);

      reset = 1'b1;
      start = 1'b1;
      tick();                       // now RUN, count 0
      start = 1'b0;
      tick();
      tick();                       // count 2

      // Register write r3 = 7 at cycle 2
      reg_write(5'd3, 32'd7);
      address_imem = 12'h100;
      tick();                       // count 3
      clear_inputs();
      check("r3_valid", 32'(trace_valid), 32'd1);
      check("r3_kind",  32'(trace_kind),  32'd1);
      check("r3_reg",   32'(trace_reg),   32'd3);
      check("r3_rdata", trace_rdata,      32'd7);
      check("r3_cycle", 32'(trace_cycle), 32'd2);
      check("r3_pc",    32'(trace_pc),    32'h100);
      check("r3_maddr", 32'(trace_maddr), 32'd0);
      trace_ready = 1'b1;
      tick();                       // count 4, popped
      trace_ready = 1'b0;
      check("pop1_valid", 32'(trace_valid), 32'd0);

      // r0 write alongside dmem write: only the dmem part counts
      reg_write(5'd0, 32'h1234);
      wren         = 1'b1;
      address_dmem = 12'd5;
      data         = 32'd9;
      address_imem = 12'h104;
      tick();                       // count 5
      clear_inputs();
      check("dm_kind",  32'(trace_kind),  32'd2);
      check("dm_reg",   32'(trace_reg),   32'd0);
      check("dm_rdata", trace_rdata,      32'd0);
      check("dm_maddr", 32'(trace_maddr), 32'd5);
      check("dm_mdata", trace_mdata,      32'd9);
      check("dm_cycle", 32'(trace_cycle), 32'd4);
      trace_ready = 1'b1;
      tick();                       // count 6
      trace_ready = 1'b0;

      // Simultaneous register and dmem write -> single kind 11 entry
      reg_write(5'd5, 32'hDEAD);
      wren         = 1'b1;
      address_dmem = 12'd7;
      data         = 32'h55;
      tick();                       // count 7
      clear_inputs();
      check("both_kind",  32'(trace_kind),  32'd3);
      check("both_reg",   32'(trace_reg),   32'd5);
      check("both_rdata", trace_rdata,      32'hDEAD);
      check("both_maddr", 32'(trace_maddr), 32'd7);
      check("both_mdata", trace_mdata,      32'h55);
      check("both_cycle", 32'(trace_cycle), 32'd6);
      trace_ready = 1'b1;
      tick();                       // count 8
      trace_ready = 1'b0;
      check("both_single", 32'(trace_valid), 32'd0);

      // Write to r0 alone is not an event
      reg_write(5'd0, 32'd1);
      tick();                       // count 9
      clear_inputs();
      check("r0_none", 32'(trace_valid), 32'd0);

      // 20 events with no reader: 16 kept, 4 dropped
      for (int i = 0; i < 20; i++) begin
         reg_write(5'd1, 32'(i));
         tick();
      end                           // count 29
      clear_inputs();
      check("ovf_valid",   32'(trace_valid), 32'd1);
      check("ovf_flag",    32'(overflow),    32'd1);
      check("ovf_dropped", 32'(dropped),     32'd4);
      check("ovf_head",    32'(trace_cycle), 32'd9);

      // Push and pop together while full: nothing dropped
      reg_write(5'd1, 32'd99);
      trace_ready = 1'b1;
      tick();                       // count 30
      clear_inputs();
      trace_ready = 1'b0;
      check("fullpp_dropped", 32'(dropped),     32'd4);
      check("fullpp_head",    32'(trace_cycle), 32'd10);

      trace_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_valid", 32'(trace_valid), 32'd1);
         check("drain_cycle", 32'(trace_cycle), (i < 15) ? 32'(10 + i) : 32'd29);
         tick();
      end
      trace_ready = 1'b0;
      check("drain_empty",  32'(trace_valid), 32'd0);
      check("drain_sticky", 32'(overflow),    32'd1);
      check("run1_nohalt",  32'(halt),        32'd0);

      for (int i = 0; i < 200 && !halt; i++) tick();
      check("run1_halt", 32'(halt), 32'd1);

      // No entries in HALTED
      reg_write(5'd4, 32'd4);
      tick();
      clear_inputs();
      check("halted_nopush", 32'(trace_valid), 32'd0);
      check("halted_stays",  32'(halt),        32'd1);

      // Re-arm: event every cycle, reader always ready; start mid-run ignored
      start = 1'b1;
      tick();                       // RUN, count 0
      start = 1'b0;
      check("rearm_halt",     32'(halt),     32'd0);
      check("rearm_overflow", 32'(overflow), 32'd0);
      check("rearm_dropped",  32'(dropped),  32'd0);
      trace_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         reg_write(5'd2, 32'(i));
         start = (i == 50);
         tick();
         check("run2_valid", 32'(trace_valid), 32'd1);
         check("run2_cycle", 32'(trace_cycle), 32'(i));
         check("run2_rdata", trace_rdata,      32'(i));
         check("run2_halt",  32'(halt),        (i == 99) ? 32'd1 : 32'd0);
      end
      clear_inputs();
      tick();
      check("run2_end_empty", 32'(trace_valid), 32'd0);
      check("run2_end_halt",  32'(halt),        32'd1);

      // Reset mid-run with 5 entries queued
      trace_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         reg_write(5'd6, 32'(i));
         tick();
      end
      clear_inputs();
      check("pre_rst_valid", 32'(trace_valid), 32'd1);
      check("pre_rst_cycle", 32'(trace_cycle), 32'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mid_rst_valid", 32'(trace_valid), 32'd0);
      check("mid_rst_halt",  32'(halt),        32'd0);
      check("mid_rst_kind",  32'(trace_kind),  32'd0);
      check("mid_rst_rdata", trace_rdata,      32'd0);

      // IDLE after reset: events ignored
      reg_write(5'd7, 32'd7);
      tick();
      clear_inputs();
      check("idle_nopush", 32'(trace_valid), 32'd0);
      check("idle_halt",   32'(halt),        32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
